hp_pattern_target: RTL
======================

# hp_pattern_target

AXI4 slave on the 48-bit/128-bit HP interface, the responder for the benchmark kernel's master port. It accepts INCR write bursts and checks each beat against an internally generated per-DW arithmetic pattern, accumulating a checksum and a mismatch count. It answers INCR read bursts with the same pattern, which makes the kernel's write and read modes self-checking in simulation and on-board loopback.

## Interface
- HP_ADDR_WIDTH, 48: AW/AR address width.
- HP_DATA_WIDTH, 128: data width; fixed at 4 DWs.
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous assert, active-low.
- hp_aw{addr,len,size,burst,valid} / hp_awready  in / out  48,8,3,2,1 / 1  write address channel.
- hp_w{data,strb,last,valid} / hp_wready  in / out  128,16,1,1 / 1  write data channel.
- hp_bresp,hp_bvalid / hp_bready  out / in  2,1 / 1  write response channel.
- hp_ar{addr,len,size,burst,valid} / hp_arready  in / out  48,8,3,2,1 / 1  read address channel.
- hp_rdata,hp_rresp,hp_rlast,hp_rvalid / hp_rready  out / in  128,2,1,1 / 1  read data channel.
- cfg_start_value  in  128  pattern seed; 4 DWs.
- cfg_stride  in  128  per-DW increment applied per beat.
- cfg_clear  in  1  single-cycle pulse: reload patterns and zero statistics.
- cfg_stall  in  4  idle cycles inserted after each W/R beat; see Configuration.
- stat_wr_beats, stat_rd_beats  out  32  accepted W beats / delivered R beats.
- stat_checksum  out  32  sum of all four DWs of every accepted W beat, mod 2^32.
- stat_err  out  16  saturating count of mismatched W beats.

## Operation
- The write FSM and the read FSM are independent. Each channel allows one outstanding burst.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch awlen, set the bad flag if awsize!=4 or awburst!=1, clear the beat counter, go to W_DATA.
  - W_DATA: wready=1 (subject to stall). Per beat:
    - Compare each DW of wdata with the matching DW of wexp, masked by wstrb bytes.
    - Add the four wdata DWs to the checksum.
    - Advance wexp by cfg_stride per DW (each DW is 32-bit, wraps).
    - Increment stat_wr_beats. Increment stat_err on any mismatch.
  - The burst ends on the beat with wlast=1, or on beat awlen+1. The bad flag is also set if wlast and beat count disagree.
  - W_RESP: bvalid=1, bresp=2'b10 if bad else 2'b00. On bready, return to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch arlen and the bad flag (same rule as write), go to R_DATA.
  - R_DATA: rvalid=1, rdata=rval, rresp from the bad flag, rlast=(beat==arlen). On each handshake, advance rval by cfg_stride per DW and increment stat_rd_beats. After the last beat, return to R_IDLE.
- Address is ignored for data generation: the pattern is stream-ordered.
- cfg_clear:
  - Sets wexp and rval to cfg_start_value.
  - Zeros all stats.
  - Does not change FSM state.
  - Wins over a same-cycle beat. That beat is still handshaked but not counted, and does not advance the pattern.
- stat_err saturates at 16'hFFFF. stat_checksum and beat counters wrap.

## Timing
- Reset values:
  - awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, rdata=0.
  - wexp=0, rval=0, all stats 0.
  - awready and arready rise on the first clk edge after rstn deasserts.
- Registered outputs only.
- AW handshake at cycle N: wready=1 at N+1.
- Last W beat at N: bvalid=1 at N+1. After the B handshake at M: awready=1 at M+1.
- AR handshake at N: first rvalid at N+1. Back-to-back beats when rready=1 and stall=0.
- Stats update the cycle after the beat.
- rdata, rlast and rresp hold stable while rvalid=1 and rready=0.
- Reset asserted mid-burst: both FSMs return to idle immediately, with no response issued.

## Configuration
- HP_PATTERN_TARGET_STALL_EN defined:
  - After each accepted W beat, wready drops for cfg_stall cycles.
  - After each R handshake, rvalid drops for cfg_stall cycles.
  - cfg_stall=0 gives full rate.
- Undefined: cfg_stall is ignored, and both channels run at full rate.

## Test plan
- Seed 0 and stride {1,1,1,1}, cfg_clear. Write 4 beats (awlen=3, size 4, burst 1) carrying {k,k,k,k} for k=0..3 -> bresp=0, stat_err=0, stat_wr_beats=4, stat_checksum=24.
- Same setup, but beat 2 DW0 corrupted to 0xFF with wstrb=16'hFFFF -> stat_err=1. With wstrb=16'hFFF0 on that beat -> stat_err=0.
- Read awlen-equivalent arlen=255 with seed {10,20,30,40} and stride {1,2,3,4} -> beat 255 rdata={265,530,795,1060}, rlast only on beat 255, rresp=0.
- awburst=2 (WRAP), awlen=1 -> 2 beats accepted, bresp=2'b10. wlast on beat 0 with awlen=1 -> bresp=2'b10.
- Read with rready toggling every cycle while a write runs concurrently -> rdata stable while stalled, both bursts complete, and stats are consistent.
- Stall macro defined with cfg_stall=3 -> wready pulses once every 4 cycles. rstn pulsed mid-read -> rvalid=0 the same cycle and arready=1 after release.

Source files
------------

// File: rtl/hp_pattern_target_if.sv
// hp_pattern_target_if: AXI4 HP bus bundle (AW/W/B/AR/R) between the kernel master
// and the pattern target.
interface hp_pattern_target_if #(
    parameter int unsigned HP_ADDR_WIDTH = 48,
    parameter int unsigned HP_DATA_WIDTH = 128
);
    localparam int unsigned STRB_W = HP_DATA_WIDTH / 8;

    logic [HP_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awvalid;
    logic                     awready;

    logic [HP_DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]        wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic [HP_ADDR_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;

    logic [HP_DATA_WIDTH-1:0] rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/hp_pattern_target.sv
// hp_pattern_target: AXI4 HP slave that checks INCR write bursts against a per-DW
// arithmetic pattern and answers reads with it. HP_PATTERN_TARGET_STALL_EN enables cfg_stall.
module hp_pattern_target (
    input  logic                 clk,
    input  logic                 rstn,
    hp_pattern_target_if.slave   hp,
    input  logic [127:0]         cfg_start_value_i,
    input  logic [127:0]         cfg_stride_i,
    input  logic                 cfg_clear_i,
    input  logic [3:0]           cfg_stall_i,
    output logic [31:0]          stat_wr_beats_o,
    output logic [31:0]          stat_rd_beats_o,
    output logic [31:0]          stat_checksum_o,
    output logic [15:0]          stat_err_o
);
    localparam int unsigned DW_W   = 32;
    localparam int unsigned NUM_DW = 4;
    localparam int unsigned DATA_W = DW_W * NUM_DW;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [7:0]        awlen_q, awlen_d, wbeat_q, wbeat_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [7:0]        arlen_q, arlen_d, rbeat_q, rbeat_d;
    logic [DATA_W-1:0] wexp_q, wexp_d, rval_q, rval_d;
    logic [31:0]       wr_beats_q, wr_beats_d, rd_beats_q, rd_beats_d;
    logic [31:0]       checksum_q, checksum_d;
    logic [15:0]       err_q, err_d;
`ifdef HP_PATTERN_TARGET_STALL_EN
    logic [3:0]        wstall_q, wstall_d, rstall_q, rstall_d;
`endif

    logic w_fire, r_fire, w_len_hit, w_end, w_miss;
    logic unused_c;

    assign w_fire    = hp.wvalid && wready_q;
    assign r_fire    = rvalid_q && hp.rready;
    assign w_len_hit = (wbeat_q == awlen_q);
    assign w_end     = hp.wlast || w_len_hit;
`ifdef HP_PATTERN_TARGET_STALL_EN
    assign unused_c  = ^{hp.awaddr, hp.araddr};
`else
    assign unused_c  = ^{hp.awaddr, hp.araddr, cfg_stall_i};
`endif

    // Per-DW wrapping increment of the pattern.
    function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] v,
                                               input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DW; i++)
            r[i*DW_W +: DW_W] = v[i*DW_W +: DW_W] + s[i*DW_W +: DW_W];
        return r;
    endfunction

    function automatic logic [31:0] dw_sum(input logic [DATA_W-1:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NUM_DW; i++) r = r + v[i*DW_W +: DW_W];
        return r;
    endfunction

    // Byte-masked compare of the incoming beat against the expected pattern.
    always_comb begin
        w_miss = 1'b0;
        for (int b = 0; b < STRB_W; b++)
            if (hp.wstrb[b] && (hp.wdata[b*8 +: 8] != wexp_q[b*8 +: 8])) w_miss = 1'b1;
    end

    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = 1'b0;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awlen_d    = awlen_q;
        wbeat_d    = wbeat_q;
        wexp_d     = wexp_q;
        wr_beats_d = wr_beats_q;
        checksum_d = checksum_q;
        err_d      = err_q;
        r_state_d  = r_state_q;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rresp_d    = rresp_q;
        arlen_d    = arlen_q;
        rbeat_d    = rbeat_q;
        rval_d     = rval_q;
        rd_beats_d = rd_beats_q;
`ifdef HP_PATTERN_TARGET_STALL_EN
        wstall_d   = wstall_q;
        rstall_d   = rstall_q;
`endif

        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (hp.awvalid && awready_q) begin
                    w_state_d = W_DATA;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    awlen_d   = hp.awlen;
                    wbeat_d   = '0;
                    bresp_d   = ((hp.awsize != 3'd4) || (hp.awburst != 2'd1)) ? 2'b10 : 2'b00;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    wbeat_d    = wbeat_q + 8'd1;
                    wexp_d     = step(wexp_q, cfg_stride_i);
                    wr_beats_d = wr_beats_q + 32'd1;
                    checksum_d = checksum_q + dw_sum(hp.wdata);
                    if (w_miss && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
                    // bresp_q carries the header error until the response is issued.
                    if (w_end) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        if (hp.wlast != w_len_hit) bresp_d = 2'b10;
                    end
`ifdef HP_PATTERN_TARGET_STALL_EN
                    else if (cfg_stall_i != 4'd0) begin
                        wready_d = 1'b0;
                        wstall_d = cfg_stall_i;
                    end
`endif
                end
`ifdef HP_PATTERN_TARGET_STALL_EN
                else if (!wready_q) begin
                    if (wstall_q <= 4'd1) wready_d = 1'b1;
                    else                  wstall_d = wstall_q - 4'd1;
                end
`endif
            end
            W_RESP: begin
                if (hp.bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = 2'b00;
                    awready_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (hp.arvalid && arready_q) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    arlen_d   = hp.arlen;
                    rbeat_d   = '0;
                    rlast_d   = (hp.arlen == 8'd0);
                    rresp_d   = ((hp.arsize != 3'd4) || (hp.arburst != 2'd1)) ? 2'b10 : 2'b00;
                end
            end
            R_DATA: begin
                if (r_fire) begin
                    rval_d     = step(rval_q, cfg_stride_i);
                    rd_beats_d = rd_beats_q + 32'd1;
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = 2'b00;
                        arready_d = 1'b1;
                    end else begin
                        rbeat_d = rbeat_q + 8'd1;
                        rlast_d = (8'(rbeat_q + 8'd1) == arlen_q);
`ifdef HP_PATTERN_TARGET_STALL_EN
                        if (cfg_stall_i != 4'd0) begin
                            rvalid_d = 1'b0;
                            rstall_d = cfg_stall_i;
                        end
`endif
                    end
                end
`ifdef HP_PATTERN_TARGET_STALL_EN
                else if (!rvalid_q) begin
                    if (rstall_q <= 4'd1) rvalid_d = 1'b1;
                    else                  rstall_d = rstall_q - 4'd1;
                end
`endif
            end
            default: r_state_d = R_IDLE;
        endcase

        // Clear overrides any same-cycle beat's effect on pattern and statistics.
        if (cfg_clear_i) begin
            wexp_d     = cfg_start_value_i;
            rval_d     = cfg_start_value_i;
            wr_beats_d = '0;
            rd_beats_d = '0;
            checksum_d = '0;
            err_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            awlen_q    <= '0;
            wbeat_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= 2'b00;
            arlen_q    <= '0;
            rbeat_q    <= '0;
            wexp_q     <= '0;
            rval_q     <= '0;
            wr_beats_q <= '0;
            rd_beats_q <= '0;
            checksum_q <= '0;
            err_q      <= '0;
`ifdef HP_PATTERN_TARGET_STALL_EN
            wstall_q   <= '0;
            rstall_q   <= '0;
`endif
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awlen_q    <= awlen_d;
            wbeat_q    <= wbeat_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rresp_q    <= rresp_d;
            arlen_q    <= arlen_d;
            rbeat_q    <= rbeat_d;
            wexp_q     <= wexp_d;
            rval_q     <= rval_d;
            wr_beats_q <= wr_beats_d;
            rd_beats_q <= rd_beats_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
`ifdef HP_PATTERN_TARGET_STALL_EN
            wstall_q   <= wstall_d;
            rstall_q   <= rstall_d;
`endif
        end
    end

    assign hp.awready      = awready_q;
    assign hp.wready       = wready_q;
    assign hp.bvalid       = bvalid_q;
    assign hp.bresp        = bresp_q;
    assign hp.arready      = arready_q;
    assign hp.rvalid       = rvalid_q;
    assign hp.rlast        = rlast_q;
    assign hp.rresp        = rresp_q;
    assign hp.rdata        = rval_q;
    assign stat_wr_beats_o = wr_beats_q;
    assign stat_rd_beats_o = rd_beats_q;
    assign stat_checksum_o = checksum_q;
    assign stat_err_o      = err_q;
endmodule
